// File: rtl/regfile_write_arbiter_pkg.sv
// regwr_pkg: shared widths, zero-register index and slot payload type for regfile_write_arbiter.
package regwr_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;
    localparam int MAX_DATA_W = 64;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_rr_grant.sv
// rr_grant: combinational one-hot round-robin picker; search starts at ptr_i and wraps upward.
module rr_grant #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);
    logic [PTR_W-1:0] cand;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = PTR_W'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of one regfile write port among NUM_REQ one-entry slots.
// Define REGWR_FORWARD_EN to add the combinational fwd_addr/fwd_hit/fwd_data lookup.
module regfile_write_arbiter
    import regwr_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 64,
    parameter int DROP_REG31 = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]      req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           wr_en,
    output logic [REG_ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]              wr_data,
    output logic                           wr_collide
`ifdef REGWR_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0]          fwd_addr,
    output logic                           fwd_hit,
    output logic [DATA_W-1:0]              fwd_data
`endif
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wr_req_t               slot_q [NUM_REQ];
    wr_req_t               slot_d [NUM_REQ];
    wr_req_t               sel;
    logic [NUM_REQ-1:0]    full_q, full_d, grant;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d, gidx;
    logic                  gany, drop, collide;
    logic                  wr_en_q, wr_en_d, wr_collide_q, wr_collide_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    rr_grant #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_grant (
        .req_i (full_q),
        .ptr_i (rr_ptr_q),
        .gnt_o (grant),
        .idx_o (gidx),
        .any_o (gany)
    );

    // A slot draining this cycle can take a new entry in the same edge.
    assign req_ready  = ~full_q | grant;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_collide = wr_collide_q;

    always_comb begin
        sel     = slot_q[gidx];
        drop    = (DROP_REG31 != 0) && (sel.addr == ZERO_REG);
        collide = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gany && !grant[i] && full_q[i] && slot_q[i].addr == sel.addr && sel.addr != ZERO_REG)
                collide = 1'b1;
        full_d = full_q & ~grant;
        slot_d = slot_q;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && req_ready[i]) begin
                full_d[i] = 1'b1;
                slot_d[i] = '{addr: req_addr[i*REG_ADDR_W +: REG_ADDR_W],
                              data: MAX_DATA_W'(req_data[i*DATA_W +: DATA_W])};
            end
        rr_ptr_d     = !gany ? rr_ptr_q : (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
        wr_en_d      = gany && !drop;
        wr_addr_d    = gany ? sel.addr : wr_addr_q;
        wr_data_d    = gany ? sel.data[DATA_W-1:0] : wr_data_q;
        wr_collide_d = collide;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q       <= '0;
            rr_ptr_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_collide_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
        end else begin
            full_q       <= full_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_collide_q <= wr_collide_d;
            for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= slot_d[i];
        end
    end

`ifdef REGWR_FORWARD_EN
    logic [PTR_W-1:0] fidx;
    // Slots are scanned in future grant order so the last one to be written overrides.
    always_comb begin
        fidx     = '0;
        fwd_hit  = wr_en_q && wr_addr_q == fwd_addr;
        fwd_data = fwd_hit ? wr_data_q : '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            fidx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (full_q[fidx] && slot_q[fidx].addr == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = slot_q[fidx].data[DATA_W-1:0];
            end
        end
        if (fwd_addr == ZERO_REG) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of the write arbiter against a slot-level model.
module tb_regfile_write_arbiter;
    localparam int N  = 2;
    localparam int DW = 64;
    localparam logic [N-1:0] ALL1 = '1;

    logic            clk, reset;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*5-1:0]  req_addr;
    logic [N*DW-1:0] req_data;
    logic            wr_en, wr_collide;
    logic [4:0]      wr_addr;
    logic [DW-1:0]   wr_data;
`ifdef REGWR_FORWARD_EN
    logic [4:0]      fwd_addr;
    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;
`endif

    int vectors = 0;
    int miscompares = 0;

    bit            mfull [N];
    logic [4:0]    maddr [N];
    logic [DW-1:0] mdata [N];
    int            mptr;
    logic          e_en, e_col;
    logic [4:0]    e_addr;
    logic [DW-1:0] e_data;
    int            wq [$];
    int            n0;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DROP_REG31(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_collide (wr_collide)
`ifdef REGWR_FORWARD_EN
        ,
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input bit v, input logic [4:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*5 +: 5]    = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic idle();
        req_valid = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mfull[i] = 1'b0;
            maddr[i] = '0;
            mdata[i] = '0;
        end
        mptr   = 0;
        e_en   = 1'b0;
        e_col  = 1'b0;
        e_addr = '0;
        e_data = '0;
    endtask

    // One clock of the reference: pick the first full slot from mptr, issue it, then load accepted requests.
    task automatic cycle();
        int g = -1;
        bit rdy [N];
        for (int k = 0; k < N; k++)
            if (g < 0 && mfull[(mptr + k) % N]) g = (mptr + k) % N;
        for (int i = 0; i < N; i++) begin
            rdy[i] = !mfull[i] || g == i;
            chk($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(rdy[i]));
        end
        e_col = 1'b0;
        if (g >= 0) begin
            for (int j = 0; j < N; j++)
                if (j != g && mfull[j] && maddr[j] == maddr[g] && maddr[g] != 5'd31) e_col = 1'b1;
            e_en     = maddr[g] != 5'd31;
            e_addr   = maddr[g];
            e_data   = mdata[g];
            mfull[g] = 1'b0;
            mptr     = (g + 1) % N;
        end else
            e_en = 1'b0;
        for (int i = 0; i < N; i++)
            if (req_valid[i] && rdy[i]) begin
                mfull[i] = 1'b1;
                maddr[i] = req_addr[i*5 +: 5];
                mdata[i] = req_data[i*DW +: DW];
            end
        @(posedge clk);
        #1;
        chk("wr_en", 64'(wr_en), 64'(e_en));
        chk("wr_addr", 64'(wr_addr), 64'(e_addr));
        chk("wr_data", wr_data, e_data);
        chk("wr_collide", 64'(wr_collide), 64'(e_col));
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
`ifdef REGWR_FORWARD_EN
        fwd_addr  = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_wr_addr", 64'(wr_addr), 64'd0);
        chk("reset_wr_data", wr_data, 64'd0);
        chk("reset_wr_collide", 64'(wr_collide), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'(ALL1));
        reset = 1'b1;
        cycle();

        drive(0, 1, 5'd5, 64'hA5);
        cycle();
        idle();
        cycle();
        chk("single_en", 64'(wr_en), 64'd1);
        chk("single_addr", 64'(wr_addr), 64'd5);
        chk("single_data", wr_data, 64'hA5);
        cycle();
        chk("single_en_after", 64'(wr_en), 64'd0);

        drive(1, 1, 5'd6, 64'h66);
        cycle();
        idle();
        repeat (2) cycle();

        drive(0, 1, 5'd3, 64'h11);
        drive(1, 1, 5'd7, 64'h22);
        cycle();
        idle();
        chk("contend_ready1", 64'(req_ready[1]), 64'd0);
        cycle();
        chk("contend_first_addr", 64'(wr_addr), 64'd3);
        chk("contend_first_data", wr_data, 64'h11);
        cycle();
        chk("contend_second_en", 64'(wr_en), 64'd1);
        chk("contend_second_addr", 64'(wr_addr), 64'd7);
        chk("contend_second_data", wr_data, 64'h22);
        cycle();

        wq.delete();
        drive(0, 1, 5'd10, 64'h100);
        drive(1, 1, 5'd11, 64'h200);
        repeat (8) begin
            cycle();
            if (wr_en) wq.push_back(int'(wr_addr));
        end
        idle();
        repeat (3) begin
            cycle();
            if (wr_en) wq.push_back(int'(wr_addr));
        end
        chk("fair_writes", 64'(wq.size()), 64'd9);
        n0 = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fair_order[%0d]", k), 64'(wq[k]), (k % 2 == 0) ? 64'd10 : 64'd11);
            if (wq[k] == 10) n0++;
        end
        chk("fair_count0", 64'(n0), 64'd4);

        drive(0, 1, 5'd2, 64'h2);
        cycle();
        idle();
        repeat (2) cycle();
        drive(1, 1, 5'd31, 64'hFF);
        cycle();
        idle();
        cycle();
        chk("zero_wr_en", 64'(wr_en), 64'd0);
        chk("zero_slot_empty", 64'(req_ready[1]), 64'd1);
        drive(0, 1, 5'd9, 64'h90);
        drive(1, 1, 5'd9, 64'h91);
        cycle();
        idle();
        cycle();
        chk("collide_pulse", 64'(wr_collide), 64'd1);
        chk("collide_first_data", wr_data, 64'h90);
        cycle();
        chk("collide_clear", 64'(wr_collide), 64'd0);
        chk("collide_second_en", 64'(wr_en), 64'd1);
        chk("collide_second_data", wr_data, 64'h91);
        cycle();

`ifdef REGWR_FORWARD_EN
        drive(0, 1, 5'd4, 64'h44);
        drive(1, 1, 5'd4, 64'h33);
        cycle();
        idle();
        cycle();
        fwd_addr = 5'd4;
        #1;
        chk("fwd_hit4", 64'(fwd_hit), 64'd1);
        chk("fwd_data4", fwd_data, 64'h33);
        fwd_addr = 5'd31;
        #1;
        chk("fwd_hit31", 64'(fwd_hit), 64'd0);
        chk("fwd_data31", fwd_data, 64'd0);
        fwd_addr = 5'd0;
        repeat (2) cycle();
`endif

        repeat (400) begin
            for (int i = 0; i < N; i++)
                drive(i, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(8, 11)),
                      {$urandom, $urandom});
            cycle();
        end
        idle();
        repeat (3) cycle();

        drive(0, 1, 5'd12, 64'hC0);
        drive(1, 1, 5'd13, 64'hD0);
        cycle();
        cycle();
        #2 reset = 1'b0;
        #1;
        chk("midrst_wr_en", 64'(wr_en), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'(ALL1));
        chk("midrst_addr", 64'(wr_addr), 64'd0);
        chk("midrst_collide", 64'(wr_collide), 64'd0);
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) cycle();
        chk("post_rst_wr_en", 64'(wr_en), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
